// File: rtl/acf_lag_accumulator_if.sv
// Readout bus of acf_lag_accumulator.
//   dump_req  : consumer -> accumulator, pulse to start streaming all bins
//   out_ready : consumer -> accumulator, beat accepted
//   out_valid : accumulator -> consumer, beat valid
//   out_data  : accumulator -> consumer, count of bin out_bin
//   out_bin   : accumulator -> consumer, lag index of the beat
//   out_last  : accumulator -> consumer, beat carries bin NUM_BINS
interface acf_lag_accumulator_if #(
  parameter int NUM_BINS  = 8,
  parameter int ACF_WIDTH = 16
);
  localparam int IDX_W = $clog2(NUM_BINS + 1);

  logic                 dump_req;
  logic                 out_ready;
  logic                 out_valid;
  logic [ACF_WIDTH-1:0] out_data;
  logic [IDX_W-1:0]     out_bin;
  logic                 out_last;

  modport master (
    input  dump_req, out_ready,
    output out_valid, out_data, out_bin, out_last
  );

  modport slave (
    output dump_req, out_ready,
    input  out_valid, out_data, out_bin, out_last
  );
endinterface

// File: rtl/acf_lag_accumulator.sv
// Photon autocorrelator: timestamps photon pulses against a free-running
// counter and accumulates coincidence counts for lags 0..NUM_BINS into
// saturating accumulators, which are streamed out over a valid/ready bus
// on request and then cleared.
//   CLK, RST  : clock, asynchronous active-high reset
//   cnt       : free-running timestamp (+1 per CLK, wraps)
//   photon    : single-cycle photon pulse
//   clear     : synchronous clear of accumulators, history and sat_flag
//   bus       : readout bus (dump_req/out_ready in, out_* out)
//   busy      : high while draining, dumping or clearing
//   sat_flag  : sticky, an increment hit an all-ones accumulator
module acf_lag_accumulator #(
  parameter int NUM_BINS  = 8,
  parameter int CNTR_SIZE = 32,
  parameter int ACF_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [CNTR_SIZE-1:0] cnt,
  input  logic                 photon,
  input  logic                 clear,
  acf_lag_accumulator_if.master bus,
  output logic                 busy,
  output logic                 sat_flag
);
  localparam int IDX_W = $clog2(NUM_BINS + 1);

  localparam logic [1:0] ST_ACCUM = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DUMP  = 2'd2;
  localparam logic [1:0] ST_CLR   = 2'd3;

  logic [1:0]           state;
  logic [CNTR_SIZE-1:0] last_ts;
  logic [CNTR_SIZE-1:0] s1_d;
  logic                 first_seen;
  logic                 s1_valid;
  logic                 s1_vd;
  // hist[j-1] set: the most recent photon had an earlier partner at lag j
  logic [NUM_BINS-1:0]  hist;
  logic [NUM_BINS-1:0]  nb;
  logic [NUM_BINS:0]    shifted;
  logic [NUM_BINS:0]    inc;
  logic [ACF_WIDTH-1:0] acc     [0:NUM_BINS];
  logic [ACF_WIDTH-1:0] acc_nxt [0:NUM_BINS];
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     dd;
  logic                 d_ok;
  logic                 sat_hit;
  logic                 zero_all;
  logic                 take_photon;
  logic                 xfer;
  logic                 last_bin;

  assign take_photon = (state == ST_ACCUM) && photon && !clear;
  assign zero_all    = clear || (state == ST_CLR);
  assign xfer        = (state == ST_DUMP) && bus.out_ready;
  assign last_bin    = (idx == IDX_W'(NUM_BINS));

  // Lags of the new photon = (lags of previous photon, plus lag 0 for the
  // previous photon itself) shifted up by d; anything past NUM_BINS drops off.
  always_comb begin
    d_ok    = s1_vd && (s1_d != '0) && (s1_d <= CNTR_SIZE'(NUM_BINS));
    dd      = d_ok ? s1_d[IDX_W-1:0] : '0;
    shifted = {hist, 1'b1} << dd;
    nb      = (s1_valid && d_ok) ? shifted[NUM_BINS:1] : '0;
    inc     = s1_valid ? {nb, 1'b1} : '0;
    sat_hit = 1'b0;
    for (int unsigned k = 0; k <= NUM_BINS; k++) begin
      acc_nxt[k] = acc[k];
      if (inc[k]) begin
        if (&acc[k]) sat_hit = 1'b1;
        else         acc_nxt[k] = acc[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ST_ACCUM;
      last_ts    <= '0;
      s1_d       <= '0;
      s1_vd      <= 1'b0;
      s1_valid   <= 1'b0;
      first_seen <= 1'b0;
      hist       <= '0;
      idx        <= '0;
      sat_flag   <= 1'b0;
      for (int unsigned k = 0; k <= NUM_BINS; k++) acc[k] <= '0;
    end else begin
      // stage 1: timestamp delta against the previous photon
      s1_valid <= take_photon;
      if (take_photon) begin
        s1_d    <= cnt - last_ts;
        s1_vd   <= first_seen;
        last_ts <= cnt;
      end

      // stage 2: accumulate; a clear also discards a pending stage-1 photon
      if (zero_all) begin
        first_seen <= 1'b0;
        hist       <= '0;
        sat_flag   <= 1'b0;
        for (int unsigned k = 0; k <= NUM_BINS; k++) acc[k] <= '0;
      end else begin
        if (take_photon) first_seen <= 1'b1;
        if (s1_valid)    hist <= nb;
        if (sat_hit)     sat_flag <= 1'b1;
        for (int unsigned k = 0; k <= NUM_BINS; k++) acc[k] <= acc_nxt[k];
      end

      case (state)
        ST_ACCUM: if (!clear && bus.dump_req) state <= ST_DRAIN;
        ST_DRAIN: begin
          idx   <= '0;
          state <= clear ? ST_ACCUM : ST_DUMP;
        end
        ST_DUMP: begin
          if (clear) begin
            state <= ST_ACCUM;
          end else if (xfer) begin
            if (last_bin) state <= ST_CLR;
            else          idx <= idx + 1'b1;
          end
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end

  assign busy          = (state != ST_ACCUM);
  assign bus.out_valid = (state == ST_DUMP);
  assign bus.out_bin   = bus.out_valid ? idx : '0;
  assign bus.out_data  = bus.out_valid ? acc[idx] : '0;
  assign bus.out_last  = bus.out_valid && last_bin;
endmodule

// File: tb/tb_acf_lag_accumulator.sv
module tb_acf_lag_accumulator;
  localparam int NB = 8;

  typedef struct {
    int          bin;
    logic [15:0] data;
    bit          last;
  } beat_t;

  logic        CLK;
  logic        RST;
  logic [31:0] cnt;
  logic        photon;
  logic        clear;
  logic        busy16, sat16, busy4, sat4;

  acf_lag_accumulator_if #(.NUM_BINS(NB), .ACF_WIDTH(16)) bus16();
  acf_lag_accumulator_if #(.NUM_BINS(NB), .ACF_WIDTH(4))  bus4();

  acf_lag_accumulator #(.NUM_BINS(NB), .CNTR_SIZE(32), .ACF_WIDTH(16)) u_dut16 (
    .CLK(CLK), .RST(RST), .cnt(cnt), .photon(photon), .clear(clear),
    .bus(bus16.master), .busy(busy16), .sat_flag(sat16)
  );

  acf_lag_accumulator #(.NUM_BINS(NB), .CNTR_SIZE(32), .ACF_WIDTH(4)) u_dut4 (
    .CLK(CLK), .RST(RST), .cnt(cnt), .photon(photon), .clear(clear),
    .bus(bus4.master), .busy(busy4), .sat_flag(sat4)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
  endtask

  // Reference model: set of photon timestamps since the last clear; a new
  // photon adds one to every lag k for which an earlier photon sits exactly
  // k counts before it (lag 0 always). Index 0 = 16-bit DUT, 1 = 4-bit DUT.
  logic [31:0] ts_q[$];
  int          acc_m [2][0:NB];
  bit          sat_m [2];
  int          maxv  [2] = '{65535, 15};

  task automatic model_clear();
    ts_q.delete();
    for (int s = 0; s < 2; s++) begin
      sat_m[s] = 1'b0;
      for (int k = 0; k <= NB; k++) acc_m[s][k] = 0;
    end
  endtask

  task automatic model_photon(input logic [31:0] t);
    bit hit;
    for (int k = 0; k <= NB; k++) begin
      hit = (k == 0);
      foreach (ts_q[i]) if (t - ts_q[i] == 32'(k)) hit = 1'b1;
      if (hit)
        for (int s = 0; s < 2; s++) begin
          if (acc_m[s][k] == maxv[s]) sat_m[s] = 1'b1;
          else acc_m[s][k]++;
        end
    end
    ts_q.push_back(t);
  endtask

  // scoreboard
  beat_t q16[$];
  beat_t q4[$];
  int    beats [2];
  bit    st_prev [2];
  logic [15:0] st_data [2];
  int    st_bin [2];

  task automatic mon_one(input int sel, input logic v, input logic r,
                         input logic [15:0] d, input int b, input logic l);
    beat_t e;
    int    qs;
    if (st_prev[sel])
      check($sformatf("stall_hold%0d", sel), {39'b0, v, b[7:0], d},
            {39'b0, 1'b1, st_bin[sel][7:0], st_data[sel]});
    if (v && r) begin
      qs = (sel == 0) ? q16.size() : q4.size();
      if (qs == 0) begin
        check($sformatf("unexpected_beat%0d", sel), {39'b0, b[7:0], d}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = (sel == 0) ? q16.pop_front() : q4.pop_front();
        check($sformatf("beat%0d_bin%0d", sel, e.bin), {39'b0, b[7:0], d, l},
              {39'b0, e.bin[7:0], e.data, e.last});
        beats[sel]++;
      end
    end
    st_prev[sel] = v && !r;
    st_data[sel] = d;
    st_bin[sel]  = b;
  endtask

  always @(negedge CLK) begin
    if (RST) begin
      st_prev[0] = 1'b0;
      st_prev[1] = 1'b0;
    end else begin
      mon_one(0, bus16.out_valid, bus16.out_ready, bus16.out_data,
              int'(bus16.out_bin), bus16.out_last);
      mon_one(1, bus4.out_valid, bus4.out_ready, 16'(bus4.out_data),
              int'(bus4.out_bin), bus4.out_last);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    cnt = cnt + 1;
  endtask

  task automatic fire();
    model_photon(cnt);
    photon = 1'b1;
    tick();
    photon = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_clear();
  endtask

  task automatic set_ready(input int mode, input int cyc);
    logic r;
    case (mode)
      0:       r = 1'b1;
      1:       r = (cyc % 3 == 0);
      default: r = 1'($urandom_range(0, 1));
    endcase
    bus16.out_ready = r;
    bus4.out_ready  = r;
  endtask

  // mode: 0 always ready, 1 pattern 1,0,0, 2 random; with_ph: photon on the
  // dump_req cycle; abort_after: assert RST once that many beats transferred
  task automatic do_dump(input int mode, input bit with_ph, input int abort_after);
    bit done;
    if (with_ph) model_photon(cnt);
    photon = with_ph;
    for (int k = 0; k <= NB; k++) begin
      q16.push_back('{k, 16'(acc_m[0][k]), k == NB});
      q4.push_back('{k, 16'(acc_m[1][k]), k == NB});
    end
    model_clear();
    beats[0] = 0;
    beats[1] = 0;
    bus16.dump_req = 1'b1;
    bus4.dump_req  = 1'b1;
    set_ready(mode, 0);
    tick();
    photon = 1'b0;
    bus16.dump_req = 1'b0;
    bus4.dump_req  = 1'b0;
    done = 1'b0;
    for (int cyc = 1; cyc < 300 && !done; cyc++) begin
      set_ready(mode, cyc);
      tick();
      if (abort_after != 0 && beats[0] >= abort_after) begin
        #1 RST = 1'b1;
        #1;
        check("rst_async_valid16", {63'b0, bus16.out_valid}, 64'd0);
        check("rst_async_valid4", {63'b0, bus4.out_valid}, 64'd0);
        check("rst_async_busy", {62'b0, busy16, busy4}, 64'd0);
        q16.delete();
        q4.delete();
        @(posedge CLK);
        #1 RST = 1'b0;
        return;
      end
      if (!busy16 && !busy4) done = 1'b1;
    end
    check("dump_done", {63'b0, done}, 64'd1);
    check("q16_drained", 64'(q16.size()), 64'd0);
    check("q4_drained", 64'(q4.size()), 64'd0);
    check("sat_after_dump", {62'b0, sat16, sat4}, {62'b0, sat_m[0], sat_m[1]});
    q16.delete();
    q4.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1'b1;
    cnt = '0;
    photon = 1'b0;
    clear = 1'b0;
    bus16.dump_req = 1'b0;
    bus4.dump_req = 1'b0;
    bus16.out_ready = 1'b0;
    bus4.out_ready = 1'b0;
    model_clear();
    idle(3);
    check("reset_valid", {62'b0, bus16.out_valid, bus4.out_valid}, 64'd0);
    check("reset_busy", {62'b0, busy16, busy4}, 64'd0);
    check("reset_sat", {62'b0, sat16, sat4}, 64'd0);
    check("reset_data", {39'b0, bus16.out_data, 4'(bus16.out_bin), bus16.out_last}, 64'd0);
    RST = 1'b0;
    idle(2);

    // lags from photons at 100, 101, 103
    cnt = 32'd100;
    fire(); fire(); idle(1); fire(); idle(3);
    do_dump(0, 1'b0, 0);
    idle(2);
    do_dump(0, 1'b0, 0);     // bins must have been cleared by the previous dump

    // counter wrap: photons at 2^32-2 and 1
    cnt = 32'hFFFF_FFFE;
    fire(); idle(2); fire(); idle(3);
    do_dump(0, 1'b0, 0);

    // lag beyond NUM_BINS
    cnt = 32'd0;
    fire(); idle(8); fire(); idle(3);
    do_dump(0, 1'b0, 0);

    // saturation of the narrow instance
    repeat (20) fire();
    idle(3);
    check("sat_flags", {62'b0, sat16, sat4}, {62'b0, sat_m[0], sat_m[1]});
    do_clear();
    idle(1);
    check("sat_after_clear", {62'b0, sat16, sat4}, 64'd0);
    do_dump(0, 1'b0, 0);

    // stalled readout
    fire(); fire(); idle(2); fire(); idle(4); fire(); idle(2);
    do_dump(1, 1'b0, 0);

    // random traffic
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(10, 40);
      for (int i = 0; i < n; i++) begin
        if (r == 2 && i == n / 2) do_clear();
        else if ($urandom_range(0, 2) == 0) fire();
        else idle(1);
      end
      do_dump($urandom_range(0, 2), r[0], 0);
      idle($urandom_range(1, 3));
    end

    // reset in the middle of a dump, then a single photon
    fire(); idle(1); fire(); idle(3);
    do_dump(0, 1'b0, 4);
    model_clear();
    idle(2);
    cnt = 32'd50;
    fire(); idle(3);
    do_dump(0, 1'b0, 0);

    idle(3);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
